// File: rtl/branch_pkg.sv
// Shared types and opcode constants for the Thumb branch sequencer.
// BRANCH_STATS_EN enables the taken/not-taken statistics counters.
package branch_pkg;

    typedef enum logic [3:0] {
        EQ, NE, CS, CC, MI, PL, VS, VC,
        HI, LS, GE, LT, GT, LE, AL, FALSE
    } cond_e;

    localparam int APSR_N = 3;
    localparam int APSR_Z = 2;
    localparam int APSR_C = 1;
    localparam int APSR_V = 0;

    typedef enum logic [1:0] {
        IDLE,
        BL2,
        REDIRECT
    } state_e;

    localparam logic [3:0] OP_BCOND = 4'b1101;
    localparam logic [4:0] OP_B     = 5'b11100;
    localparam logic [4:0] OP_BL1   = 5'b11110;
    localparam logic [1:0] OP_BL2   = 2'b11;
    localparam logic [8:0] OP_BX    = 9'b010001110;

endpackage

// File: rtl/branch_ctrl_if.sv
// Decode/fetch-facing bundle of the branch sequencer.
// BRANCH_STATS_EN adds the statistics counter outputs.
interface branch_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              i_valid;
    logic              o_ready;
    logic [15:0]       i_ir;
    logic [ADDR_W-1:0] i_pc;
    logic [3:0]        i_apsr;
    logic [ADDR_W-1:0] i_rm_data;
    logic              o_redirect_valid;
    logic [ADDR_W-1:0] o_redirect_pc;
    logic              i_redirect_ready;
    logic              o_lr_we;
    logic [ADDR_W-1:0] o_lr_data;
    logic              o_done;
    logic              o_fault;
`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0]  o_taken_cnt;
    logic [CNT_W-1:0]  o_not_taken_cnt;

    modport master (
        output i_valid, i_ir, i_pc, i_apsr, i_rm_data, i_redirect_ready,
        input  o_ready, o_redirect_valid, o_redirect_pc,
        input  o_lr_we, o_lr_data, o_done, o_fault,
        input  o_taken_cnt, o_not_taken_cnt
    );

    modport slave (
        input  i_valid, i_ir, i_pc, i_apsr, i_rm_data, i_redirect_ready,
        output o_ready, o_redirect_valid, o_redirect_pc,
        output o_lr_we, o_lr_data, o_done, o_fault,
        output o_taken_cnt, o_not_taken_cnt
    );
`else
    localparam int unused_cnt_w = CNT_W;

    modport master (
        output i_valid, i_ir, i_pc, i_apsr, i_rm_data, i_redirect_ready,
        input  o_ready, o_redirect_valid, o_redirect_pc,
        input  o_lr_we, o_lr_data, o_done, o_fault
    );

    modport slave (
        input  i_valid, i_ir, i_pc, i_apsr, i_rm_data, i_redirect_ready,
        output o_ready, o_redirect_valid, o_redirect_pc,
        output o_lr_we, o_lr_data, o_done, o_fault
    );
`endif
endinterface

// File: rtl/branch_ctrl_conditions.sv
// Thumb condition evaluator: cccc field of a B<cond> against APSR flags.
// Pure combinational; BRANCH_STATS_EN has no effect here.
module conditions
    import branch_pkg::*;
(
    input  logic [15:0] i_ir,
    input  logic [3:0]  i_apsr,
    output logic        o_met
);
    cond_e cond;
    logic  n, z, c, v;
    logic  unused_ir;

    assign cond      = cond_e'(i_ir[11:8]);
    assign n         = i_apsr[APSR_N];
    assign z         = i_apsr[APSR_Z];
    assign c         = i_apsr[APSR_C];
    assign v         = i_apsr[APSR_V];
    assign unused_ir = ^{i_ir[15:12], i_ir[7:0]};

    always_comb begin
        o_met = 1'b0;
        unique case (cond)
            EQ:    o_met = z;
            NE:    o_met = !z;
            CS:    o_met = c;
            CC:    o_met = !c;
            MI:    o_met = n;
            PL:    o_met = !n;
            VS:    o_met = v;
            VC:    o_met = !v;
            HI:    o_met = c && !z;
            LS:    o_met = !c || z;
            GE:    o_met = (n == v);
            LT:    o_met = (n != v);
            GT:    o_met = !z && (n == v);
            LE:    o_met = z || (n != v);
            AL:    o_met = 1'b1;
            FALSE: o_met = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_ctrl.sv
// Thumb branch sequencer: B<cond>, B, BL pair and BX with redirect handshake.
// Define BRANCH_STATS_EN for saturating taken/not-taken counters.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic         i_clk,
    input  logic         i_reset,
    branch_ctrl_if.slave bus
);
    localparam logic [ADDR_W-1:0] EVEN = {{(ADDR_W-1){1'b1}}, 1'b0};
    localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

    state_e            state_q, state_d;
    logic              met, accept, hs;
    logic              is_bcond, is_b, is_bl1, is_bx, is_bl2;
    logic              bl_s_q;
    logic [9:0]        bl_imm10_q;
    logic [ADDR_W-1:0] bl_pc_q;
    logic              i1, i2;
    logic [24:0]       bl_off;
    logic [ADDR_W-1:0] pc4, bl_pc4;
    logic [ADDR_W-1:0] bcond_tgt, b_tgt, bx_tgt, bl_tgt;
    logic              rv_q, rv_d, lr_we_q, lr_we_d;
    logic              done_q, done_d, fault_q, fault_d;
    logic [ADDR_W-1:0] rpc_q, rpc_d, lr_q, lr_d;

    conditions u_cond (
        .i_ir   (bus.i_ir),
        .i_apsr (bus.i_apsr),
        .o_met  (met)
    );

    assign bus.o_ready = (state_q != REDIRECT);
    assign accept      = bus.i_valid && bus.o_ready;
    assign hs          = rv_q && bus.i_redirect_ready;

    assign is_bcond = (bus.i_ir[15:12] == OP_BCOND)
                   && (bus.i_ir[11:9] != 3'b111);
    assign is_b     = (bus.i_ir[15:11] == OP_B);
    assign is_bl1   = (bus.i_ir[15:11] == OP_BL1);
    assign is_bx    = (bus.i_ir[15:7] == OP_BX)
                   && (bus.i_ir[2:0] == 3'b000);
    assign is_bl2   = (bus.i_ir[15:14] == OP_BL2) && bus.i_ir[12];

    assign pc4       = bus.i_pc + FOUR;
    assign bcond_tgt = (pc4 + {{(ADDR_W-9){bus.i_ir[7]}},
                               bus.i_ir[7:0], 1'b0}) & EVEN;
    assign b_tgt     = (pc4 + {{(ADDR_W-12){bus.i_ir[10]}},
                               bus.i_ir[10:0], 1'b0}) & EVEN;
    assign bx_tgt    = bus.i_rm_data & EVEN;

    // J1/J2 encode the upper offset bits relative to S
    assign i1     = ~(bus.i_ir[13] ^ bl_s_q);
    assign i2     = ~(bus.i_ir[11] ^ bl_s_q);
    assign bl_off = {bl_s_q, i1, i2, bl_imm10_q, bus.i_ir[10:0], 1'b0};
    assign bl_pc4 = bl_pc_q + FOUR;
    assign bl_tgt = (bl_pc4 + {{(ADDR_W-25){bl_s_q}}, bl_off}) & EVEN;

    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        is_b, is_bx: state_d = REDIRECT;
                        is_bcond:    if (met) state_d = REDIRECT;
                        is_bl1:      state_d = BL2;
                        default:     ;
                    endcase
                end
            end
            BL2: begin
                if (accept) state_d = is_bl2 ? REDIRECT : IDLE;
            end
            REDIRECT: begin
                if (bus.i_redirect_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rv_d    = rv_q && !bus.i_redirect_ready;
        rpc_d   = rpc_q;
        lr_we_d = 1'b0;
        lr_d    = lr_q;
        done_d  = hs;
        fault_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        is_b: begin
                            rv_d  = 1'b1;
                            rpc_d = b_tgt;
                        end
                        is_bx: begin
                            rv_d  = 1'b1;
                            rpc_d = bx_tgt;
                        end
                        is_bcond: begin
                            if (met) begin
                                rv_d  = 1'b1;
                                rpc_d = bcond_tgt;
                            end else begin
                                done_d = 1'b1;
                            end
                        end
                        is_bl1:  ;
                        default: done_d = 1'b1;
                    endcase
                end
            end
            BL2: begin
                if (accept && is_bl2) begin
                    rv_d    = 1'b1;
                    rpc_d   = bl_tgt;
                    lr_we_d = 1'b1;
                    lr_d    = bl_pc4 | ADDR_W'(1);
                end else if (accept) begin
                    fault_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rv_q       <= 1'b0;
            rpc_q      <= '0;
            lr_we_q    <= 1'b0;
            lr_q       <= '0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            bl_s_q     <= 1'b0;
            bl_imm10_q <= '0;
            bl_pc_q    <= '0;
        end else begin
            rv_q    <= rv_d;
            rpc_q   <= rpc_d;
            lr_we_q <= lr_we_d;
            lr_q    <= lr_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            if (state_q == IDLE && accept && is_bl1) begin
                bl_s_q     <= bus.i_ir[10];
                bl_imm10_q <= bus.i_ir[9:0];
                bl_pc_q    <= bus.i_pc;
            end
        end
    end

    assign bus.o_redirect_valid = rv_q;
    assign bus.o_redirect_pc    = rpc_q;
    assign bus.o_lr_we          = lr_we_q;
    assign bus.o_lr_data        = lr_q;
    assign bus.o_done           = done_q;
    assign bus.o_fault          = fault_q;

`ifdef BRANCH_STATS_EN
    logic             nt;
    logic [CNT_W-1:0] taken_q, nt_q;

    assign nt = (state_q == IDLE) && accept && is_bcond && !met;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            taken_q <= '0;
            nt_q    <= '0;
        end else begin
            if (hs && !(&taken_q)) taken_q <= taken_q + 1'b1;
            if (nt && !(&nt_q))    nt_q    <= nt_q + 1'b1;
        end
    end

    assign bus.o_taken_cnt     = taken_q;
    assign bus.o_not_taken_cnt = nt_q;
`else
    localparam int unused_cnt_w = CNT_W;
`endif
endmodule
